// File: rtl/hd_memory_write_ctrl_pkg.sv
// Shared types for the HD memory write front-end: request mode and controller state.
package pkg_hd_memory;

    typedef enum logic {
        WordMode = 1'b0,
        RowMode  = 1'b1
    } write_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2,
        FINISH  = 2'd3
    } hd_wr_state_e;

    localparam int DEF_ROW_WIDTH  = 2048;
    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_NUM_ROWS   = 16;

endpackage

// File: rtl/hd_memory_write_ctrl_row_assembler.sv
// Row buffer that packs consecutive stream words into one hypervector row, lane 0 first.
module hd_row_assembler
#(
    parameter int ROW_WIDTH  = 2048,
    parameter int WORD_WIDTH = 32,
    localparam int WORDS_PER_ROW = ROW_WIDTH / WORD_WIDTH,
    localparam int WA_W = $clog2(WORDS_PER_ROW)
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic [ROW_WIDTH-1:0]  row_o,
    output logic                  last_o
);

    localparam logic [WA_W-1:0] LAST_LANE = WA_W'(WORDS_PER_ROW - 1);
    localparam logic [WA_W-1:0] LANE_ONE  = WA_W'(1);

    logic [ROW_WIDTH-1:0] r_buf;
    logic [WA_W-1:0]      r_lane;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_buf  <= '0;
            r_lane <= '0;
        end else if (push_i) begin
            r_buf  <= row_o;
            r_lane <= last_o ? '0 : r_lane + LANE_ONE;
        end
    end

    // row_o already contains the incoming word so the last push can be committed directly.
    always_comb begin
        row_o = r_buf;
        row_o[r_lane*WORD_WIDTH +: WORD_WIDTH] = data_i;
    end

    assign last_o = (r_lane == LAST_LANE);

endmodule

// File: rtl/hd_memory_write_ctrl.sv
// HD memory write front-end: turns a word stream into single-word writes (WordMode)
// or assembled full-row writes (RowMode), one outstanding request at a time.
module hd_memory_write_ctrl
    import pkg_hd_memory::*;
#(
    parameter int ROW_WIDTH  = DEF_ROW_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    localparam int WORDS_PER_ROW = ROW_WIDTH / WORD_WIDTH,
    localparam int WA_W = $clog2(WORDS_PER_ROW),
    localparam int RA_W = $clog2(NUM_ROWS)
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  write_mode_t           cfg_mode_i,
    input  logic [RA_W-1:0]       cfg_row_addr_i,
    input  logic [WA_W-1:0]       cfg_word_addr_i,
    input  logic [WA_W:0]         cfg_len_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic                  mem_we_o,
    output write_mode_t           mem_mode_o,
    output logic [RA_W-1:0]       mem_row_addr_o,
    output logic [WA_W-1:0]       mem_word_addr_o,
    output logic [ROW_WIDTH-1:0]  mem_wdata_o,
    input  logic                  mem_gnt_i,
    output logic                  busy_o,
    output logic                  done_o
);

    if (ROW_WIDTH % WORD_WIDTH != 0) begin : g_width_check
        $error("ROW_WIDTH must be a multiple of WORD_WIDTH");
    end

    localparam logic [WA_W-1:0] LAST_WA = WA_W'(WORDS_PER_ROW - 1);
    localparam logic [WA_W-1:0] WA_ONE  = WA_W'(1);
    localparam logic [WA_W:0]   REM_ONE = (WA_W+1)'(1);

    hd_wr_state_e         r_state;
    write_mode_t          r_mode;
    write_mode_t          r_mem_mode;
    logic [RA_W-1:0]      r_row;
    logic [RA_W-1:0]      r_mem_row;
    logic [WA_W-1:0]      r_waddr;
    logic [WA_W-1:0]      r_mem_waddr;
    logic [WA_W:0]        r_rem;
    logic                 r_we;
    logic                 r_done;
    logic [ROW_WIDTH-1:0] r_wdata;

    logic [ROW_WIDTH-1:0] w_word_row;
    logic [ROW_WIDTH-1:0] w_row;
    logic                 w_last;
    logic                 w_start;
    logic                 w_abort;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_clear;
    logic                 w_granted;

    assign w_start      = (r_state == IDLE) && start_i;
    assign w_abort      = (r_state != IDLE) && abort_i;
    assign data_ready_o = (r_state == COLLECT) && ((r_mode == RowMode) || !r_we);
    assign w_accept     = data_valid_i && data_ready_o;
    assign w_push       = w_accept && (r_mode == RowMode) && !w_abort;
    assign w_clear      = w_start || w_abort;
    assign w_granted    = r_we && mem_gnt_i;

    always_comb begin
        w_word_row = '0;
        w_word_row[r_waddr*WORD_WIDTH +: WORD_WIDTH] = data_i;
    end

    hd_row_assembler #(
        .ROW_WIDTH  (ROW_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_row_assembler (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_clear),
        .push_i  (w_push),
        .data_i  (data_i),
        .row_o   (w_row),
        .last_o  (w_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_mode      <= WordMode;
            r_mem_mode  <= WordMode;
            r_row       <= '0;
            r_mem_row   <= '0;
            r_waddr     <= '0;
            r_mem_waddr <= '0;
            r_rem       <= '0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_done <= 1'b0;
            // Abort drops any request that was not granted this cycle.
            if (w_abort) begin
                r_state <= IDLE;
                r_we    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start_i) begin
                            r_mode  <= cfg_mode_i;
                            r_row   <= cfg_row_addr_i;
                            r_waddr <= cfg_word_addr_i;
                            r_rem   <= cfg_len_i;
                            if (cfg_mode_i == WordMode && cfg_len_i == '0) begin
                                r_state <= FINISH;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= COLLECT;
                            end
                        end
                    end
                    COLLECT: begin
                        if (r_mode == RowMode) begin
                            if (w_accept && w_last) begin
                                r_state     <= COMMIT;
                                r_we        <= 1'b1;
                                r_mem_mode  <= RowMode;
                                r_mem_row   <= r_row;
                                r_mem_waddr <= '0;
                                r_wdata     <= w_row;
                            end
                        end else if (w_accept) begin
                            r_we        <= 1'b1;
                            r_mem_mode  <= WordMode;
                            r_mem_row   <= r_row;
                            r_mem_waddr <= r_waddr;
                            r_wdata     <= w_word_row;
                        end else if (w_granted) begin
                            r_we    <= 1'b0;
                            r_waddr <= (r_waddr == LAST_WA) ? '0 : r_waddr + WA_ONE;
                            r_rem   <= r_rem - REM_ONE;
                            if (r_rem == REM_ONE) begin
                                r_state <= FINISH;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    COMMIT: begin
                        if (w_granted) begin
                            r_we    <= 1'b0;
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                    FINISH:  r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign mem_we_o        = r_we;
    assign mem_mode_o      = r_mem_mode;
    assign mem_row_addr_o  = r_mem_row;
    assign mem_word_addr_o = r_mem_waddr;
    assign mem_wdata_o     = r_wdata;
    assign busy_o          = (r_state != IDLE);
    assign done_o          = r_done;

endmodule
